// File: rtl/sim_mmio_pkg.sv
// sim_mmio_pkg: register offsets, STATUS bit positions and the responder's bus state type.
// Shared by the responder, the sim harness and the bench.
package sim_mmio_pkg;
    localparam logic [7:0] OFF_CYCLE_LO = 8'h00;
    localparam logic [7:0] OFF_CYCLE_HI = 8'h04;
    localparam logic [7:0] OFF_TOHOST   = 8'h08;
    localparam logic [7:0] OFF_TXDATA   = 8'h0C;
    localparam logic [7:0] OFF_STATUS   = 8'h10;
    localparam int ST_FULL    = 0;
    localparam int ST_EMPTY   = 1;
    localparam int ST_CNT_LSB = 8;
    localparam int ST_DONE    = 31;
    typedef enum logic {S_IDLE, S_RESP} state_t;
endpackage

// File: rtl/sim_mmio_responder_if.sv
// sim_mmio_responder_if: CPU load/store port plus console and exit signals of the sim MMIO responder.
interface sim_mmio_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  tx_data;
    logic        done;
    logic        pass;
    logic [30:0] exit_code;
    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_wstrb, tx_ready,
        input  req_ready, rsp_valid, rsp_rdata, tx_valid, tx_data, done, pass, exit_code
    );
    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_wstrb, tx_ready,
        output req_ready, rsp_valid, rsp_rdata, tx_valid, tx_data, done, pass, exit_code
    );
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with full/empty/count; a push into a full FIFO lands when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic do_push, do_pop;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign full    = count == CW'(DEPTH);
    assign empty   = count == '0;
    assign rdata   = mem[rp];
    always_ff @(posedge clk)
        if (do_push) mem[wp] <= wdata;
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (do_push) wp <= wp + AW'(1);
            if (do_pop) rp <= rp + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/sim_mmio_responder.sv
// sim_mmio_responder: sim-only MMIO target with 64-bit cycle counter, console FIFO and TOHOST exit register.
// Define SIM_MMIO_WDOG_EN to compile in the hang watchdog.
module sim_mmio_responder
    import sim_mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
    parameter int          FIFO_DEPTH  = 16,
    parameter logic [31:0] WDOG_CYCLES = 32'd100000
) (
    input logic                 clk,
    input logic                 rstn,
    sim_mmio_responder_if.slave bus
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    state_t state_q, state_d;
    logic [63:0] cyc;
    logic [31:0] cyc_hi_snap, rdata_d, rsp_rdata_q, status;
    logic [7:0] off, head;
    logic [CW-1:0] count;
    logic [30:0] exit_q;
    logic hit, is_tx, stall, accept, push, pop, full, empty, tohost_wr, wdog_hit, done_q, pass_q, unused;
    assign off       = bus.req_addr[7:0];
    assign hit       = bus.req_addr[31:8] == BASE_ADDR[31:8];
    assign is_tx     = hit && bus.req_we && off == OFF_TXDATA;
    // a full FIFO can still take the byte if the harness pops in the same cycle
    assign stall     = is_tx && full && !bus.tx_ready;
    assign accept    = bus.req_valid && bus.req_ready;
    assign push      = accept && is_tx && bus.req_wstrb[0];
    assign pop       = !empty && bus.tx_ready;
    assign tohost_wr = accept && hit && bus.req_we && off == OFF_TOHOST && bus.req_wdata != '0;
    assign bus.req_ready = state_q == S_IDLE && !stall;
    assign bus.rsp_valid = state_q == S_RESP;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.tx_valid  = !empty;
    assign bus.tx_data   = empty ? '0 : head;
    assign bus.done      = done_q;
    assign bus.pass      = pass_q;
    assign bus.exit_code = exit_q;
    always_comb state_d = (state_q == S_IDLE && accept) ? S_RESP : S_IDLE;
    always_comb begin
        status = '0;
        status[ST_FULL] = full;
        status[ST_EMPTY] = empty;
        status[ST_CNT_LSB +: 8] = 8'(count);
        status[ST_DONE] = done_q;
    end
    always_comb begin
        rdata_d = '0;
        if (hit && !bus.req_we)
            rdata_d = off == OFF_CYCLE_LO ? cyc[31:0] :
                      off == OFF_CYCLE_HI ? cyc_hi_snap :
                      off == OFF_STATUS   ? status : '0;
    end
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            cyc         <= '0;
            cyc_hi_snap <= '0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cyc         <= cyc + 64'd1;
            rsp_rdata_q <= accept ? rdata_d : '0;
            // snapshot taken with the LO read so a following HI read cannot tear
            if (accept && hit && !bus.req_we && off == OFF_CYCLE_LO) cyc_hi_snap <= cyc[63:32];
        end
    end
    always_ff @(posedge clk) begin
        if (!rstn) begin
            done_q <= 1'b0;
            pass_q <= 1'b0;
            exit_q <= '0;
        end else if (!done_q && tohost_wr) begin
            done_q <= 1'b1;
            pass_q <= bus.req_wdata == 32'd1;
            exit_q <= bus.req_wdata[31:1];
        end else if (wdog_hit) begin
            done_q <= 1'b1;
            pass_q <= 1'b0;
            exit_q <= '1;
        end
    end
`ifdef SIM_MMIO_WDOG_EN
    logic [31:0] wdog;
    assign wdog_hit = !done_q && !push && wdog == WDOG_CYCLES - 32'd1;
    always_ff @(posedge clk) begin
        if (!rstn || done_q || push) wdog <= '0;
        else wdog <= wdog + 32'd1;
    end
    assign unused = ^bus.req_wstrb[3:1];
`else
    assign wdog_hit = 1'b0;
    assign unused = ^{bus.req_wstrb[3:1], WDOG_CYCLES};
`endif
    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (push),
        .wdata (bus.req_wdata[7:0]),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );
endmodule

// File: tb/tb_sim_mmio_responder.sv
// tb_sim_mmio_responder: randomized scoreboard bench for sim_mmio_responder against a queue/arithmetic model.
module tb_sim_mmio_responder;
    import sim_mmio_pkg::*;
    localparam logic [31:0] BASE = 32'h1000_0000;
    localparam int DEPTH = 16;
    localparam int WD = 2000;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic tr = 1'b0, rr = 1'b0, rand_mode = 1'b0;
    int checks = 0, errors = 0;
    logic [31:0] exp_q[$];
    logic [7:0] txq[$];
    longint unsigned edges = 0, cyc_off = 0;
    logic [31:0] hi_snap = '0;
    logic m_done = 1'b0, m_pass = 1'b0;
    logic [30:0] m_exit = '0;

    sim_mmio_responder_if bif();
    sim_mmio_responder #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH), .WDOG_CYCLES(WD)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bif)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edges <= rstn ? edges + 1 : 0;
    always @(posedge clk) rr <= 1'($urandom_range(0, 1));
    assign bif.tx_ready = rand_mode ? rr : tr;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // scoreboard monitors: bus responses and console bytes
    always @(negedge clk) if (rstn) begin
        if (bif.rsp_valid) begin
            if (exp_q.size() == 0) chk("rsp_extra", 64'(bif.rsp_valid), 64'd0);
            else chk("rsp_rdata", 64'(bif.rsp_rdata), 64'(exp_q.pop_front()));
        end
        if (bif.tx_valid && bif.tx_ready) begin
            if (txq.size() == 0) chk("tx_extra", 64'(bif.tx_valid), 64'd0);
            else chk("tx_data", 64'(bif.tx_data), 64'(txq.pop_front()));
        end
    end

    // model effect of a transaction accepted at the coming edge
    task automatic predict(input logic we, input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] ws);
        logic [63:0] c;
        logic [31:0] e;
        c = cyc_off + edges;
        e = '0;
        if (addr[31:8] == BASE[31:8]) begin
            if (!we) begin
                if (addr[7:0] == OFF_CYCLE_LO) begin
                    e = c[31:0];
                    hi_snap = c[63:32];
                end else if (addr[7:0] == OFF_CYCLE_HI) e = hi_snap;
                else if (addr[7:0] == OFF_STATUS)
                    e = {m_done, 15'd0, 8'(txq.size()), 6'd0, txq.size() == 0, txq.size() == DEPTH};
            end else if (addr[7:0] == OFF_TOHOST && wd != 0 && !m_done) begin
                m_done = 1'b1;
                m_pass = wd == 32'd1;
                m_exit = wd[31:1];
            end else if (addr[7:0] == OFF_TXDATA && ws[0]) txq.push_back(wd[7:0]);
        end
        exp_q.push_back(e);
    endtask

    task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] ws);
        int n;
        n = 0;
        @(posedge clk); #1;
        bif.req_valid = 1'b1;
        bif.req_we = we;
        bif.req_addr = addr;
        bif.req_wdata = wd;
        bif.req_wstrb = ws;
        @(negedge clk);
        while (!bif.req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bif.req_ready) chk("req_ready_timeout", 64'(bif.req_ready), 64'd1);
        else predict(we, addr, wd, ws);
        @(posedge clk); #1;
        bif.req_valid = 1'b0;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        bif.req_valid = 1'b0;
        tr = 1'b0;
        rand_mode = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 64'(bif.req_ready), 64'd1);
        chk("rst_rsp_valid", 64'(bif.rsp_valid), 64'd0);
        chk("rst_rsp_rdata", 64'(bif.rsp_rdata), 64'd0);
        chk("rst_tx_valid", 64'(bif.tx_valid), 64'd0);
        chk("rst_tx_data", 64'(bif.tx_data), 64'd0);
        chk("rst_done", 64'(bif.done), 64'd0);
        chk("rst_pass", 64'(bif.pass), 64'd0);
        chk("rst_exit", 64'(bif.exit_code), 64'd0);
        exp_q.delete();
        txq.delete();
        m_done = 1'b0;
        m_pass = 1'b0;
        m_exit = '0;
        cyc_off = 0;
        hi_snap = '0;
        @(posedge clk); #1;
        rstn = 1'b1;
    endtask

    task automatic chk_exit();
        chk("done", 64'(bif.done), 64'(m_done));
        chk("pass", 64'(bif.pass), 64'(m_pass));
        chk("exit_code", 64'(bif.exit_code), 64'(m_exit));
    endtask

    initial begin
        int k, n;
        logic [31:0] w;
        bif.req_valid = 1'b0;
        bif.req_we = 1'b0;
        bif.req_addr = '0;
        bif.req_wdata = '0;
        bif.req_wstrb = '0;
        do_reset();
        // counter read pair right after reset
        xact(1'b0, BASE + 32'(OFF_CYCLE_LO), '0, '0);
        xact(1'b0, BASE + 32'(OFF_CYCLE_HI), '0, '0);
        // preload near the 32-bit boundary; the HI snapshot must not tear
        @(negedge clk);
        force dut.cyc = 64'h0000_0000_FFFF_FFFE;
        cyc_off = 64'h0000_0000_FFFF_FFFE - edges;
        #1 release dut.cyc;
        xact(1'b0, BASE + 32'(OFF_CYCLE_LO), '0, '0);
        repeat (2) @(posedge clk);
        xact(1'b0, BASE + 32'(OFF_CYCLE_HI), '0, '0);
        xact(1'b0, BASE + 32'(OFF_CYCLE_LO), '0, '0);
        xact(1'b0, BASE + 32'(OFF_CYCLE_HI), '0, '0);
        // fill the FIFO with the harness stalled, then stall the 17th store
        for (int i = 0; i < DEPTH; i++) xact(1'b1, BASE + 32'(OFF_TXDATA), $urandom, 4'b0001 | 4'($urandom));
        xact(1'b0, BASE + 32'(OFF_STATUS), '0, '0);
        w = $urandom;
        @(posedge clk); #1;
        bif.req_valid = 1'b1;
        bif.req_we = 1'b1;
        bif.req_addr = BASE + 32'(OFF_TXDATA);
        bif.req_wdata = w;
        bif.req_wstrb = 4'b0001;
        repeat (3) begin
            @(negedge clk);
            chk("full_stall", 64'(bif.req_ready), 64'd0);
        end
        @(posedge clk); #1;
        tr = 1'b1;
        @(negedge clk);
        chk("stall_release", 64'(bif.req_ready), 64'd1);
        predict(1'b1, BASE + 32'(OFF_TXDATA), w, 4'b0001);
        @(posedge clk); #1;
        bif.req_valid = 1'b0;
        repeat (25) @(posedge clk);
        chk("tx_drained", 64'(txq.size()), 64'd0);
        // randomized mix with a randomly stalling harness
        rand_mode = 1'b1;
        for (int i = 0; i < 80; i++) begin
            k = $urandom_range(0, 6);
            w = $urandom;
            case (k)
                0: xact(1'b0, BASE + 32'(OFF_CYCLE_LO), w, '0);
                1: xact(1'b0, BASE + 32'(OFF_CYCLE_HI), w, '0);
                2: xact(1'b1, BASE + 32'(OFF_TXDATA), w, 4'($urandom));
                3: xact(1'b0, BASE + 32'h8 + 32'(4 * $urandom_range(0, 61)), w, '0);
                4: xact(1'b1, BASE + 32'h14 + 32'(4 * $urandom_range(0, 58)), w, 4'hF);
                5: xact(1'($urandom_range(0, 1)), BASE + 32'h100 + 32'(4 * $urandom_range(0, 4)), w, 4'hF);
                default: xact(1'b1, BASE + 32'(OFF_TOHOST), '0, 4'hF);
            endcase
        end
        chk_exit();
        rand_mode = 1'b0;
        tr = 1'b1;
        repeat (40) @(posedge clk);
        chk("rand_drained", 64'(txq.size()), 64'd0);
        // leave bytes in the FIFO and reset while a response is pending
        tr = 1'b0;
        for (int i = 0; i < 3; i++) xact(1'b1, BASE + 32'(OFF_TXDATA), $urandom, 4'hF);
        xact(1'b0, BASE + 32'(OFF_CYCLE_LO), '0, '0);
        do_reset();
        // pass exit, then a later exit is ignored
        xact(1'b1, BASE + 32'(OFF_TOHOST), 32'd1, 4'hF);
        chk_exit();
        xact(1'b1, BASE + 32'(OFF_TOHOST), 32'd7, 4'hF);
        chk_exit();
        xact(1'b0, BASE + 32'(OFF_STATUS), '0, '0);
        do_reset();
        // zero write ignored, then a failing exit code
        xact(1'b1, BASE + 32'(OFF_TOHOST), 32'd0, 4'hF);
        chk_exit();
        xact(1'b1, BASE + 32'(OFF_TOHOST), 32'd5, 4'hF);
        chk_exit();
        xact(1'b1, BASE + 32'(OFF_TXDATA), 32'h41, 4'h1);
        tr = 1'b1;
        repeat (4) @(posedge clk);
        chk("post_done_drain", 64'(txq.size()), 64'd0);
`ifdef SIM_MMIO_WDOG_EN
        do_reset();
        n = 0;
        while (!bif.done && n < WD + 50) begin
            @(negedge clk);
            n++;
        end
        chk("wdog_cycles", 64'(n), 64'(WD + 1));
        chk("wdog_pass", 64'(bif.pass), 64'd0);
        chk("wdog_exit", 64'(bif.exit_code), 64'h7FFF_FFFF);
        do_reset();
`endif
        repeat (3) @(posedge clk);
        chk("rsp_left", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule
